// File: rtl/eight_bit_1_16_demux_reg_if.sv
// Bus bundle for the registered 1-to-16 byte distributor.
// The producer side offers in_data/in_valid with a 4-bit select and sees in_ready.
// The 16 consumers see the lane registers a..p and lane_full, and return lane_ack.
// With DEMUX_OVF_CNT_EN defined, the bundle also carries ovf_cnt and ovf_clr.
interface eight_bit_1_16_demux_reg_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        s0;
  logic        s1;
  logic        s2;
  logic        s3;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  c;
  logic [7:0]  d;
  logic [7:0]  e;
  logic [7:0]  f;
  logic [7:0]  g;
  logic [7:0]  h;
  logic [7:0]  i;
  logic [7:0]  j;
  logic [7:0]  k;
  logic [7:0]  l;
  logic [7:0]  m;
  logic [7:0]  n;
  logic [7:0]  o;
  logic [7:0]  p;
  logic [15:0] lane_full;
  logic [15:0] lane_ack;
  logic [4:0]  occupancy;
`ifdef DEMUX_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
  logic        ovf_clr;

  // Producer and consumers: drive requests, observe lanes and status.
  modport master (
    output in_data, in_valid, s0, s1, s2, s3, lane_ack, ovf_clr,
    input  in_ready, a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
    input  lane_full, occupancy, ovf_cnt
  );

  // Distributor: consumes requests, drives lanes and status.
  modport slave (
    input  in_data, in_valid, s0, s1, s2, s3, lane_ack, ovf_clr,
    output in_ready, a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
    output lane_full, occupancy, ovf_cnt
  );
`else
  // Producer and consumers: drive requests, observe lanes and status.
  modport master (
    output in_data, in_valid, s0, s1, s2, s3, lane_ack,
    input  in_ready, a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
    input  lane_full, occupancy
  );

  // Distributor: consumes requests, drives lanes and status.
  modport slave (
    input  in_data, in_valid, s0, s1, s2, s3, lane_ack,
    output in_ready, a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
    output lane_full, occupancy
  );
`endif
endinterface

// File: rtl/eight_bit_1_16_demux_reg.sv
// Registered 1-to-16 byte distributor.
// One input byte is steered by sel = {s3,s2,s1,s0} into one of 16 lane holding
// registers (a..p). A lane accepts only while empty; its consumer frees it with lane_ack.
// occupancy tracks the number of full lanes (0..16).
// Optional feature macro: DEMUX_OVF_CNT_EN adds a saturating stall counter
// (ovf_cnt) with a synchronous clear input (ovf_clr).
module eight_bit_1_16_demux_reg #(
  parameter bit         CLR_ON_ACK = 1'b0,
  parameter logic [7:0] RST_DATA   = 8'h00
) (
  input logic clk,
  input logic rst_n,
  eight_bit_1_16_demux_reg_if.slave bus
);

  // Number of set bits in a 16-bit vector, i.e. how many lanes are acked at once.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int q = 0; q < 16; q++) begin
      cnt = cnt + {4'd0, v[q]};
    end
    return cnt;
  endfunction

  logic [7:0]  lane_r [16];
  logic [15:0] lane_full_r;
  logic [4:0]  occ_r;

  logic [3:0]  sel_s;
  logic        in_ready_s;
  logic        accept_s;
  logic [15:0] ack_vld_s;
  logic [15:0] accept_onehot_s;
  logic [15:0] full_nxt_s;
  logic [4:0]  occ_nxt_s;

  assign sel_s      = {bus.s3, bus.s2, bus.s1, bus.s0};
  // Ready depends only on the current select and flags; an ack this cycle does
  // not open the lane until the next cycle.
  assign in_ready_s = ~lane_full_r[sel_s];
  assign accept_s   = bus.in_valid & in_ready_s;
  // Acks on empty lanes are dropped here so they cannot disturb the count.
  assign ack_vld_s  = bus.lane_ack & lane_full_r;

  // Next flag vector and occupancy from this cycle's accept and valid acks.
  always_comb begin
    accept_onehot_s = 16'h0000;
    if (accept_s) begin
      accept_onehot_s[sel_s] = 1'b1;
    end else begin
      accept_onehot_s = 16'h0000;
    end
    full_nxt_s = (lane_full_r & ~ack_vld_s) | accept_onehot_s;
    occ_nxt_s  = occ_r + {4'd0, accept_s} - popcount16(ack_vld_s);
  end

  // Lane data: load on accept, optionally clear on a taken ack, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < 16; q++) begin
        lane_r[q] <= RST_DATA;
      end
    end else begin
      for (int q = 0; q < 16; q++) begin
        if (accept_onehot_s[q]) begin
          lane_r[q] <= bus.in_data;
        end else if (CLR_ON_ACK && ack_vld_s[q]) begin
          lane_r[q] <= 8'h00;
        end else begin
          lane_r[q] <= lane_r[q];
        end
      end
    end
  end

  // Full flags and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_full_r <= 16'h0000;
      occ_r       <= 5'd0;
    end else begin
      lane_full_r <= full_nxt_s;
      occ_r       <= occ_nxt_s;
    end
  end

`ifdef DEMUX_OVF_CNT_EN
  logic [7:0] ovf_cnt_r;

  // Saturating count of stalled offers; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= 8'h00;
    end else if (bus.ovf_clr) begin
      ovf_cnt_r <= 8'h00;
    end else if (bus.in_valid && !in_ready_s && (ovf_cnt_r != 8'hFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 8'd1;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_r;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.lane_full = lane_full_r;
  assign bus.occupancy = occ_r;
  assign bus.a = lane_r[0];
  assign bus.b = lane_r[1];
  assign bus.c = lane_r[2];
  assign bus.d = lane_r[3];
  assign bus.e = lane_r[4];
  assign bus.f = lane_r[5];
  assign bus.g = lane_r[6];
  assign bus.h = lane_r[7];
  assign bus.i = lane_r[8];
  assign bus.j = lane_r[9];
  assign bus.k = lane_r[10];
  assign bus.l = lane_r[11];
  assign bus.m = lane_r[12];
  assign bus.n = lane_r[13];
  assign bus.o = lane_r[14];
  assign bus.p = lane_r[15];

endmodule

// File: tb/tb_eight_bit_1_16_demux_reg.sv
// Self-checking bench for eight_bit_1_16_demux_reg.
// Two instances share the same stimulus: dut0 with default parameters and
// dut1 with CLR_ON_ACK = 1 and a non-zero RST_DATA.
module tb_eight_bit_1_16_demux_reg;

  localparam logic [7:0] RST1 = 8'h5A;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  eight_bit_1_16_demux_reg_if if0();
  eight_bit_1_16_demux_reg_if if1();

  eight_bit_1_16_demux_reg #(.CLR_ON_ACK(1'b0), .RST_DATA(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  eight_bit_1_16_demux_reg #(.CLR_ON_ACK(1'b1), .RST_DATA(RST1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  logic [127:0] lanes0;
  logic [127:0] lanes1;
  assign lanes0 = {if0.p, if0.o, if0.n, if0.m, if0.l, if0.k, if0.j, if0.i,
                   if0.h, if0.g, if0.f, if0.e, if0.d, if0.c, if0.b, if0.a};
  assign lanes1 = {if1.p, if1.o, if1.n, if1.m, if1.l, if1.k, if1.j, if1.i,
                   if1.h, if1.g, if1.f, if1.e, if1.d, if1.c, if1.b, if1.a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lane contents, full flags, stall counter.
  bit         m_full [16];
  logic [7:0] m_lane [2][16];
  int         m_ovf;

  function automatic int m_occ();
    int c;
    c = 0;
    for (int q = 0; q < 16; q++) c += m_full[q] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [15:0] m_full_vec();
    logic [15:0] v;
    for (int q = 0; q < 16; q++) v[q] = m_full[q];
    return v;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < 16; q++) begin
      m_full[q]    = 1'b0;
      m_lane[0][q] = 8'h00;
      m_lane[1][q] = RST1;
    end
    m_ovf = 0;
  endtask

  task automatic model_step(input bit v, input int sel, input logic [7:0] data,
                            input logic [15:0] ack, input bit clr);
    bit rdy;
    rdy = !m_full[sel];
    for (int q = 0; q < 16; q++) begin
      if (ack[q] && m_full[q]) begin
        m_full[q]    = 1'b0;
        m_lane[1][q] = 8'h00;
      end
    end
    if (v && rdy) begin
      m_full[sel]    = 1'b1;
      m_lane[0][sel] = data;
      m_lane[1][sel] = data;
    end
    if (clr) m_ovf = 0;
    else if (v && !rdy && m_ovf < 255) m_ovf = m_ovf + 1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int sel, input logic [7:0] data,
                       input logic [15:0] ack, input bit clr);
    logic [3:0] s;
    s = 4'(sel);
    if0.in_valid = v;  if1.in_valid = v;
    if0.in_data = data; if1.in_data = data;
    if0.s0 = s[0]; if0.s1 = s[1]; if0.s2 = s[2]; if0.s3 = s[3];
    if1.s0 = s[0]; if1.s1 = s[1]; if1.s2 = s[2]; if1.s3 = s[3];
    if0.lane_ack = ack; if1.lane_ack = ack;
`ifdef DEMUX_OVF_CNT_EN
    if0.ovf_clr = clr; if1.ovf_clr = clr;
`else
    if (clr) begin
      if0.in_valid = v;
    end
`endif
  endtask

  task automatic check_state(input string nm);
    chk({nm, " full0"}, if0.lane_full, m_full_vec());
    chk({nm, " full1"}, if1.lane_full, m_full_vec());
    chk({nm, " occ0"}, {11'd0, if0.occupancy}, 16'(m_occ()));
    chk({nm, " occ1"}, {11'd0, if1.occupancy}, 16'(m_occ()));
    for (int q = 0; q < 16; q++) begin
      chk($sformatf("%s lane0[%0d]", nm, q), {8'd0, lanes0[q*8 +: 8]}, {8'd0, m_lane[0][q]});
      chk($sformatf("%s lane1[%0d]", nm, q), {8'd0, lanes1[q*8 +: 8]}, {8'd0, m_lane[1][q]});
    end
`ifdef DEMUX_OVF_CNT_EN
    chk({nm, " ovf0"}, {8'd0, if0.ovf_cnt}, 16'(m_ovf));
    chk({nm, " ovf1"}, {8'd0, if1.ovf_cnt}, 16'(m_ovf));
`endif
  endtask

  // One clock: drive, check ready before the edge, update model, check after.
  task automatic cycle(input string nm, input bit v, input int sel, input logic [7:0] data,
                       input logic [15:0] ack, input bit clr);
    drive(v, sel, data, ack, clr);
    #1;
    chk({nm, " rdy0"}, {15'd0, if0.in_ready}, {15'd0, !m_full[sel]});
    chk({nm, " rdy1"}, {15'd0, if1.in_ready}, {15'd0, !m_full[sel]});
    @(posedge clk);
    model_step(v, sel, data, ack, clr);
    @(negedge clk);
    check_state(nm);
  endtask

  typedef struct {
    bit          v;
    int          sel;
    logic [7:0]  data;
    logic [15:0] ack;
    bit          exp_rdy;
    logic [15:0] exp_full;
    logic [4:0]  exp_occ;
  } vec_t;

  vec_t vecs [11];

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{1'b1,  0, 8'hA5, 16'h0000, 1'b1, 16'h0001, 5'd1};
    vecs[1]  = '{1'b1, 15, 8'h3C, 16'h0000, 1'b1, 16'h8001, 5'd2};
    vecs[2]  = '{1'b1,  0, 8'hFF, 16'h0000, 1'b0, 16'h8001, 5'd2};
    vecs[3]  = '{1'b0,  0, 8'h00, 16'h0001, 1'b0, 16'h8000, 5'd1};
    vecs[4]  = '{1'b1,  5, 8'h11, 16'h0002, 1'b1, 16'h8020, 5'd2};
    vecs[5]  = '{1'b1,  5, 8'h77, 16'h0000, 1'b0, 16'h8020, 5'd2};
    vecs[6]  = '{1'b0,  5, 8'h00, 16'h0020, 1'b0, 16'h8000, 5'd1};
    vecs[7]  = '{1'b1,  5, 8'h77, 16'h0000, 1'b1, 16'h8020, 5'd2};
    vecs[8]  = '{1'b1,  9, 8'h99, 16'h0000, 1'b1, 16'h8220, 5'd3};
    vecs[9]  = '{1'b1,  2, 8'h22, 16'h0200, 1'b1, 16'h8024, 5'd3};
    vecs[10] = '{1'b0,  3, 8'h00, 16'hFFFF, 1'b1, 16'h0000, 5'd0};

    // Reset and idle.
    rst_n = 1'b0;
    drive(1'b0, 0, 8'h00, 16'h0000, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    chk("reset rdy", {15'd0, if0.in_ready}, 16'h0001);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int t = 0; t < 11; t++) begin
      drive(vecs[t].v, vecs[t].sel, vecs[t].data, vecs[t].ack, 1'b0);
      #1;
      chk($sformatf("vec%0d table rdy", t), {15'd0, if0.in_ready}, {15'd0, vecs[t].exp_rdy});
      cycle($sformatf("vec%0d", t), vecs[t].v, vecs[t].sel, vecs[t].data, vecs[t].ack, 1'b0);
      chk($sformatf("vec%0d table full", t), if0.lane_full, vecs[t].exp_full);
      chk($sformatf("vec%0d table occ", t), {11'd0, if1.occupancy}, {11'd0, vecs[t].exp_occ});
    end

    // Fill all lanes, check stall on every select, then release all at once.
    for (int q = 0; q < 16; q++) cycle("fill", 1'b1, q, 8'(q), 16'h0000, 1'b0);
    chk("fill occ", {11'd0, if0.occupancy}, 16'd16);
    for (int q = 0; q < 16; q++) begin
      drive(1'b0, q, 8'h00, 16'h0000, 1'b0);
      #1;
      chk($sformatf("fill rdy sel%0d", q), {15'd0, if0.in_ready}, 16'h0000);
    end
    cycle("ackall", 1'b0, 0, 8'h00, 16'hFFFF, 1'b0);
    chk("ackall occ", {11'd0, if0.occupancy}, 16'd0);
    chk("ackall full", if1.lane_full, 16'h0000);

    // Randomized traffic against the model.
    for (int r = 0; r < 400; r++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), 8'($urandom),
            16'($urandom & $urandom & $urandom), ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-stream: flags must clear before any clock edge.
    drive(1'b1, 4, 8'hEE, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post rst", 1'b1, 0, 8'h42, 16'h0000, 1'b0);

`ifdef DEMUX_OVF_CNT_EN
    // Saturating stall counter, then clear with a stall present.
    for (int r = 0; r < 300; r++) cycle("stall", 1'b1, 0, 8'h13, 16'h0000, 1'b0);
    chk("ovf sat", {8'd0, if0.ovf_cnt}, 16'h00FF);
    cycle("ovf clr", 1'b1, 0, 8'h13, 16'h0000, 1'b1);
    chk("ovf clr val", {8'd0, if1.ovf_cnt}, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eight_bit_1_16_demux_reg.md
Name: eight_bit_1_16_demux_reg

Overview:
Registered 1-to-16 byte distributor, the write-side counterpart of the 16:1 byte selector.
- One 8-bit input byte is steered by a 4-bit select (s0..s3) into one of 16 lane holding registers (a..p).
- A valid/ready handshake guards the input; each lane has its own full flag and a per-lane ack.
- Sits between a single byte producer and 16 lane consumers; lane ordering a..p matches select codes 0..15.

Parameters:
- CLR_ON_ACK, 0, 1 = lane data register is cleared to 8'h00 when its ack is taken; 0 = data is retained (only the flag clears).
- RST_DATA, 8'h00, reset value loaded into all 16 lane data registers.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  byte to distribute
- in_valid  input  1  producer offers in_data this cycle
- in_ready  output  1  target lane is empty; transfer occurs when in_valid and in_ready are both 1
- s0, s1, s2, s3  input  1 each  lane select; sel = {s3,s2,s1,s0}, s0 is the LSB
- a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p  output  8 each  lane data registers for sel 0..15
- lane_full  output  16  bit n = lane n holds unconsumed data
- lane_ack  input  16  bit n = consumer of lane n takes the data this cycle
- occupancy  output  5  number of full lanes, 0..16

Behaviour:
- Reset (rst_n low, asynchronous):
  - all lanes load RST_DATA;
  - lane_full = 16'h0000;
  - occupancy = 0;
  - in_ready follows the combinational rule below (1 after reset).
- in_ready = ~lane_full[sel]. This is combinational from the current select and flags only; there is no same-cycle bypass from lane_ack.
- Accept: when in_valid & in_ready at a rising edge:
  - lane[sel] <= in_data;
  - lane_full[sel] <= 1.
  - Latency: data and flag are visible the cycle after acceptance.
- Consume: when lane_ack[n] & lane_full[n] at a rising edge:
  - lane_full[n] <= 0;
  - if CLR_ON_ACK = 1, lane[n] <= 8'h00.
  - lane_ack[n] on an empty lane is ignored: no state change.
- Simultaneous events:
  - Accept on lane x and ack on lane y (x != y): both take effect in the same cycle.
  - Accept and ack on the same lane cannot coincide, because accept requires the lane to be empty.
  - Multiple acks in one cycle are all honoured.
- Hold: in_data and sel are don't-care when in_valid = 0. While in_valid & ~in_ready, no state changes. The producer may change sel while stalled, and in_ready re-evaluates against the new sel.
- occupancy is registered and updated each cycle:
  - occupancy_next = occupancy + accept - (number of valid acks).
  - Range 0..16 is guaranteed by construction; it never wraps.
- Lane outputs are driven directly from their registers. They are stable between writes and are not gated by lane_full.
- Reset mid-operation: all flags clear immediately and asynchronously. An in-flight handshake in that cycle is dropped.

Optional Feature:
- Macro: DEMUX_OVF_CNT_EN
- Defined:
  - adds output port ovf_cnt [7:0] (reset 8'h00);
  - it increments by 1 on every rising edge with in_valid & ~in_ready;
  - it saturates at 8'hFF, with no wrap;
  - it also adds input ovf_clr [1]: a synchronous clear to 0 that has priority over increment in the same cycle.
- Undefined: neither port exists, and stall cycles are not counted. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - in_ready = 1, lane_full = 16'h0000, occupancy = 0, all lanes = RST_DATA.
- Write 8'hA5 to sel 0 and 8'h3C to sel 15 on consecutive cycles:
  - a = 8'hA5 and p = 8'h3C one cycle after each accept;
  - lane_full = 16'h8001;
  - occupancy = 2.
- Second write to full lane 5 (in_data 8'h77, lane holds 8'h11):
  - in_ready = 0 and f stays 8'h11;
  - after lane_ack[5] for one cycle, in_ready = 1 and the retried write lands 8'h77.
- Fill all 16 lanes with values 8'h00..8'h0F:
  - occupancy = 16;
  - in_ready = 0 for every sel;
  - lane_ack = 16'hFFFF for one cycle brings occupancy to 0 and lane_full to 16'h0000.
- Same-cycle accept on lane 2 and ack on lane 9 (both preconditions met):
  - next cycle lane_full[2] = 1 and lane_full[9] = 0, occupancy unchanged;
  - with CLR_ON_ACK = 1, j = 8'h00.
- With DEMUX_OVF_CNT_EN, hold in_valid on a full lane for 300 cycles:
  - ovf_cnt = 8'hFF (saturated);
  - a cycle with ovf_clr = 1 and a stall present gives ovf_cnt = 0.
  - Also assert rst_n low mid-stream: flags clear without waiting for a clock edge.
